// File: rtl/dispatch4.sv
// One-to-four valid/ready stream dispatcher with a one-entry output register per channel.
// Optional round-robin steering (ignores dest_in) when DISPATCH4_RR_EN is defined.
module dispatch4 #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic [DW-1:0]   data_in,
  input  logic [1:0]      dest_in,
  output logic            ready_out,
  output logic [3:0]      valid_out,
  output logic [4*DW-1:0] data_out,
  input  logic [3:0]      ready_in
);

  logic [1:0]          sel;
  logic                accept;
  logic [3:0]          load;
  logic [3:0]          drain;
  logic [3:0]          slot_valid;
  logic [3:0][DW-1:0]  slot_data;

`ifdef DISPATCH4_RR_EN
  logic [1:0] rr_ptr;
  logic       unused_dest;

  assign unused_dest = ^dest_in;
  assign sel         = rr_ptr;

  // Pointer moves only on an accepted beat, so idle cycles keep the rotation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 2'd0;
    end else if (accept) begin
      rr_ptr <= rr_ptr + 2'd1;
    end
  end
`else
  assign sel = dest_in;
`endif

  // A full slot can still take a beat when it is being drained in the same cycle.
  assign ready_out = ~slot_valid[sel] | ready_in[sel];
  assign accept    = valid_in & ready_out;
  assign drain     = slot_valid & ready_in;

  always_comb begin
    load = 4'b0000;
    if (accept) begin
      load[sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= 4'b0000;
      slot_data  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load[i]) begin
          slot_valid[i] <= 1'b1;
          slot_data[i]  <= data_in;
        end else if (drain[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign valid_out = slot_valid;
  assign data_out  = slot_data;

endmodule

// File: tb/tb_dispatch4.sv
// Directed bench for dispatch4 (DW=8) with per-channel scoreboard queues.
// Build with DISPATCH4_RR_EN defined to run the round-robin sequence instead.
module tb_dispatch4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            valid_in;
  logic [DW-1:0]   data_in;
  logic [1:0]      dest_in;
  logic            ready_out;
  logic [3:0]      valid_out;
  logic [4*DW-1:0] data_out;
  logic [3:0]      ready_in;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] exp_q [4][$];
  logic [3:0]    exp_valid;
  logic [1:0]    rr_exp;

  dispatch4 #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .dest_in   (dest_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .data_out  (data_out),
    .ready_in  (ready_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    exp_valid = 4'b0000;
    rr_exp    = 2'd0;
  endtask

  // Samples mid-cycle, scores drains and accepts, then advances one clock.
  task automatic tick();
    logic [1:0] ch;
    logic [3:0] nxt;
    #3;
    check("valid_out", 32'(valid_out), 32'(exp_valid));
    nxt = exp_valid;
    for (int i = 0; i < 4; i++) begin
      if (exp_valid[i]) begin
        if (exp_q[i].size() == 0) begin
          check($sformatf("queue_ch%0d", i), 32'd0, 32'd1);
        end else begin
          check($sformatf("data_ch%0d", i), 32'(data_out[i*DW +: DW]), 32'(exp_q[i][0]));
          if (ready_in[i]) begin
            void'(exp_q[i].pop_front());
            nxt[i] = 1'b0;
          end
        end
      end
    end
    if (valid_in && ready_out) begin
`ifdef DISPATCH4_RR_EN
      ch     = rr_exp;
      rr_exp = rr_exp + 2'd1;
`else
      ch = dest_in;
`endif
      exp_q[ch].push_back(data_in);
      nxt[ch] = 1'b1;
    end
    exp_valid = nxt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] route_data [4];
    route_data = '{8'h21, 8'h43, 8'h65, 8'h87};
    rst_n    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    dest_in  = 2'd0;
    ready_in = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(valid_out), 32'h0);
    check("reset_data", data_out, 32'h0);
    check("reset_ready", 32'(ready_out), 32'h1);
    rst_n = 1'b1;
    tick();

`ifndef DISPATCH4_RR_EN
    // Routing: one beat to each channel, nothing drains.
    for (int d = 0; d < 4; d++) begin
      valid_in = 1'b1;
      dest_in  = 2'(d);
      data_in  = route_data[d];
      tick();
    end
    valid_in = 1'b0;
    tick();
    check("route_valid", 32'(valid_out), 32'hF);
    check("route_data", data_out, 32'h87654321);
    for (int d = 0; d < 4; d++) begin
      dest_in = 2'(d);
      #1;
      check($sformatf("full_ready_d%0d", d), 32'(ready_out), 32'h0);
    end

    // Backpressure on slot 2, then same-cycle drain and reload.
    valid_in = 1'b1;
    dest_in  = 2'd2;
    data_in  = 8'hAA;
    #1;
    check("bp_ready_low", 32'(ready_out), 32'h0);
    tick();
    check("bp_held", 32'(data_out[23:16]), 32'h65);
    ready_in = 4'b0100;
    #1;
    check("bp_ready_high", 32'(ready_out), 32'h1);
    tick();
    valid_in = 1'b0;
    ready_in = 4'b0000;
    #1;
    check("bp_new_data", 32'(data_out[23:16]), 32'hAA);
    check("bp_new_valid", 32'(valid_out[2]), 32'h1);
    tick();
    ready_in = 4'b1111;
    tick();
    ready_in = 4'b0000;
    tick();
    check("flush_empty", 32'(valid_out), 32'h0);

    // Streaming into channel 1 with the consumer always ready.
    ready_in = 4'b0010;
    dest_in  = 2'd1;
    for (int b = 1; b <= 4; b++) begin
      valid_in = 1'b1;
      data_in  = 8'(b);
      #1;
      check($sformatf("stream_ready_b%0d", b), 32'(ready_out), 32'h1);
      tick();
    end
    valid_in = 1'b0;
    tick();
    tick();
    check("stream_done", 32'(valid_out), 32'h0);

    // Independent drain of slots 0 and 3 while 1 and 2 hold.
    ready_in = 4'b0000;
    for (int d = 0; d < 4; d++) begin
      valid_in = 1'b1;
      dest_in  = 2'(d);
      data_in  = 8'hC0 + 8'(d);
      tick();
    end
    valid_in = 1'b0;
    ready_in = 4'b1001;
    tick();
    ready_in = 4'b0000;
    #1;
    check("indep_valid", 32'(valid_out), 32'h6);
    check("indep_ch1", 32'(data_out[15:8]), 32'hC1);
    check("indep_ch2", 32'(data_out[23:16]), 32'hC2);
    tick();

    // Reset mid-cycle with slots full and a beat on offer.
    valid_in = 1'b1;
    dest_in  = 2'd0;
    data_in  = 8'h77;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_valid", 32'(valid_out), 32'h0);
    check("midrst_data", data_out, 32'h0);
    check("midrst_ready", 32'(ready_out), 32'h1);
    @(posedge clk);
    #1;
    check("midrst_no_accept", 32'(valid_out), 32'h0);
    rst_n    = 1'b1;
    valid_in = 1'b1;
    dest_in  = 2'd3;
    data_in  = 8'h5A;
    tick();
    valid_in = 1'b0;
    #1;
    check("restart_valid", 32'(valid_out), 32'h8);
    check("restart_data", 32'(data_out[31:24]), 32'h5A);
    tick();
`else
    // Round-robin: six beats with an idle cycle after the third.
    ready_in = 4'b1111;
    for (int b = 0; b < 6; b++) begin
      if (b == 3) begin
        valid_in = 1'b0;
        tick();
      end
      valid_in = 1'b1;
      dest_in  = 2'(3 - (b % 4));
      data_in  = 8'h10 + 8'(b);
      #1;
      check($sformatf("rr_ready_b%0d", b), 32'(ready_out), 32'h1);
      tick();
      check($sformatf("rr_chan_b%0d", b), 32'(valid_out), 32'(4'b0001 << (b % 4)));
    end
    valid_in = 1'b0;
    tick();
    tick();
    check("rr_done", 32'(valid_out), 32'h0);

    ready_in = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_valid", 32'(valid_out), 32'h0);
    check("midrst_data", data_out, 32'h0);
    check("midrst_ready", 32'(ready_out), 32'h1);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'h5A;
    tick();
    valid_in = 1'b0;
    #1;
    check("restart_ch0", 32'(valid_out), 32'h1);
    tick();
`endif

    for (int i = 0; i < 4; i++) begin
      check($sformatf("leftover_ch%0d", i), 32'(exp_q[i].size()), 32'(exp_valid[i]));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
